// File: rtl/mm_prefetch_pkg.sv
// Shared types for the instruction prefetcher.
//   branch_sel_e  : redirect source encoding of branch_i
//   fetch_entry_t : one buffered instruction word with its address and bus error
//   word_align()  : clears the byte-offset bits of a fetch address
package mm_prefetch_pkg;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_JALR = 2'b01,
      BR_JAL  = 2'b10,
      BR_TRAP = 2'b11
   } branch_sel_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] rdata;
      logic        err;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/mm_fetch_fifo_n.sv
// Circular-buffer FIFO holding fetched instruction words.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (storage is reset too)
//   clear_i       : drop all entries; wins over push/pop in the same cycle
//   push_i/data_i : write one entry (accepted when not full, or full with a pop)
//   pop_i         : remove the head entry (ignored when empty)
//   data_o        : head entry, read straight out of storage
//   count_o       : number of valid entries
module mm_fetch_fifo_n
   import mm_prefetch_pkg::*;
#(
   parameter int unsigned Depth = 3
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         clear_i,
   input  logic                         push_i,
   input  fetch_entry_t                 data_i,
   input  logic                         pop_i,
   output fetch_entry_t                 data_o,
   output logic [$clog2(Depth+1)-1:0]   count_o
);

   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   fetch_entry_t    mem_q [Depth];
   logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0] cnt_q;
   logic            do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop  = pop_i && (cnt_q != '0);
   assign do_push = push_i && ((cnt_q != CntW'(Depth)) || do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (clear_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/mm_prefetch_queue.sv
// Instruction prefetcher between the IF stage and a 32-bit instruction bus.
// Keeps up to NumReqs granted-but-unreturned requests and a FifoDepth-entry
// buffer of returned words; a redirect (branch_i != 0) discards everything
// in flight and restarts fetching at the selected target.
// Ports:
//   clk_i, rst_ni               : clock, asynchronous active-low reset
//   req_i                       : fetch enable
//   branch_i                    : redirect select (00 none, 01 JALR, 10 JAL, 11 TrapVec)
//   addr_jalr_i, addr_jal_i     : redirect targets
//   ready_i                     : consumer takes the head word
//   valid_o/rdata_o/addr_o/err_o: head word, its address and bus error flag
//   instr_req_o/instr_addr_o    : bus request and word-aligned address
//   instr_gnt_i                 : bus grant
//   instr_rvalid_i/rdata_i/err_i: in-order bus response
//   busy_o                      : requests outstanding or a request is up
// Build option: define MM_PREFETCH_BYPASS_EN to forward a response straight
// to the outputs when the buffer is empty (zero-cycle rvalid to valid_o).
module mm_prefetch_queue
   import mm_prefetch_pkg::*;
#(
   parameter int unsigned NumReqs   = 2,
   parameter int unsigned FifoDepth = 3,
   parameter logic [31:0] TrapVec   = 32'h80
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic [1:0]  branch_i,
   input  logic [31:0] addr_jalr_i,
   input  logic [31:0] addr_jal_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] rdata_o,
   output logic [31:0] addr_o,
   output logic        err_o,
   output logic        instr_req_o,
   input  logic        instr_gnt_i,
   output logic [31:0] instr_addr_o,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i,
   input  logic        instr_rvalid_i,
   output logic        busy_o
);

   localparam int unsigned OutW  = $clog2(NumReqs + 1);
   localparam int unsigned FifoW = $clog2(FifoDepth + 1);
   localparam int unsigned OPtrW = (NumReqs > 1) ? $clog2(NumReqs) : 1;

   branch_sel_e     br_sel;
   logic            branch;
   logic [31:0]     target;

   logic [31:0]     next_addr_q, next_addr_d;
   logic            started_q, started_d;
   logic            held_q, held_d;
   logic [31:0]     held_addr_q, held_addr_d;
   logic            held_disc_q, held_disc_d;

   logic [31:0]     out_addr_q [NumReqs];
   logic            out_disc_q [NumReqs];
   logic [OPtrW-1:0] out_rd_q, out_wr_q;
   logic [OutW-1:0] out_cnt_q, out_cnt_d;

   logic [FifoW-1:0] fifo_cnt;
   logic            fifo_valid, fifo_push, fifo_pop;
   fetch_entry_t    fifo_head, rsp_entry, head;

   logic            credit_ok, new_req, gnt_fire, rsp_fire, rsp_keep, push_disc;
   logic [31:0]     issue_addr;

   function automatic logic [OPtrW-1:0] optr_inc(input logic [OPtrW-1:0] p);
      return (p == OPtrW'(NumReqs - 1)) ? '0 : p + 1'b1;
   endfunction

   assign br_sel = branch_sel_e'(branch_i);
   assign branch = (br_sel != BR_NONE);

   always_comb begin
      case (br_sel)
         BR_JALR: target = addr_jalr_i;
         BR_JAL:  target = addr_jal_i;
         default: target = TrapVec;
      endcase
   end

   // Words already buffered plus words still coming must fit in the FIFO.
   // A redirect empties the FIFO and discards all in-flight words, so it may
   // always issue.
   assign credit_ok  = (int'(fifo_cnt) + int'(out_cnt_q)) < int'(FifoDepth);
   // Nothing is fetched until the first redirect after reset.
   assign new_req    = !held_q && req_i && (started_q || branch) &&
                       (out_cnt_q < OutW'(NumReqs)) && (credit_ok || branch);
   assign issue_addr = branch ? word_align(target) : next_addr_q;

   assign instr_req_o  = held_q | new_req;
   assign instr_addr_o = held_q ? held_addr_q : issue_addr;
   assign busy_o       = (out_cnt_q != '0) | instr_req_o;

   assign gnt_fire  = instr_req_o & instr_gnt_i;
   assign rsp_fire  = instr_rvalid_i & (out_cnt_q != '0);
   // A response popped in the same cycle as a redirect is stale as well.
   assign rsp_keep  = rsp_fire & !out_disc_q[out_rd_q] & !branch;
   assign push_disc = held_q & (held_disc_q | branch);

   always_comb begin
      next_addr_d = next_addr_q;
      if (new_req)     next_addr_d = issue_addr + 32'd4;
      else if (branch) next_addr_d = word_align(target);

      started_d   = started_q | branch;
      held_d      = held_q ? !instr_gnt_i : (new_req & !instr_gnt_i);
      held_addr_d = held_q ? held_addr_q : issue_addr;
      held_disc_d = held_q & (held_disc_q | branch) & !instr_gnt_i;
      out_cnt_d   = out_cnt_q + OutW'(gnt_fire) - OutW'(rsp_fire);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         next_addr_q <= '0;
         started_q   <= 1'b0;
         held_q      <= 1'b0;
         held_addr_q <= '0;
         held_disc_q <= 1'b0;
         out_cnt_q   <= '0;
         out_rd_q    <= '0;
         out_wr_q    <= '0;
         for (int i = 0; i < NumReqs; i++) begin
            out_addr_q[i] <= '0;
            out_disc_q[i] <= 1'b0;
         end
      end else begin
         next_addr_q <= next_addr_d;
         started_q   <= started_d;
         held_q      <= held_d;
         held_addr_q <= held_addr_d;
         held_disc_q <= held_disc_d;
         out_cnt_q   <= out_cnt_d;
         if (branch) begin
            for (int i = 0; i < NumReqs; i++) out_disc_q[i] <= 1'b1;
         end
         // Written after the blanket discard so a freshly granted redirect
         // target keeps its own discard bit.
         if (gnt_fire) begin
            out_addr_q[out_wr_q] <= instr_addr_o;
            out_disc_q[out_wr_q] <= push_disc;
            out_wr_q             <= optr_inc(out_wr_q);
         end
         if (rsp_fire) out_rd_q <= optr_inc(out_rd_q);
      end
   end

   always_comb begin
      rsp_entry       = '0;
      rsp_entry.addr  = out_addr_q[out_rd_q];
      rsp_entry.rdata = instr_rdata_i;
      rsp_entry.err   = instr_err_i;
   end

   assign fifo_valid = (fifo_cnt != '0);

`ifdef MM_PREFETCH_BYPASS_EN
   logic bypass;
   assign bypass    = rsp_keep & !fifo_valid;
   assign valid_o   = fifo_valid | bypass;
   assign head      = bypass ? rsp_entry : fifo_head;
   assign fifo_pop  = fifo_valid & ready_i;
   assign fifo_push = rsp_keep & !(bypass & ready_i);
`else
   assign valid_o   = fifo_valid;
   assign head      = fifo_head;
   assign fifo_pop  = fifo_valid & ready_i;
   assign fifo_push = rsp_keep;
`endif

   assign rdata_o = head.rdata;
   assign addr_o  = head.addr;
   assign err_o   = head.err;

   mm_fetch_fifo_n #(.Depth(FifoDepth)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (branch),
      .push_i  (fifo_push),
      .data_i  (rsp_entry),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .count_o (fifo_cnt)
   );

endmodule

// File: tb/tb_mm_prefetch_queue.sv
module tb_mm_prefetch_queue;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_i;
   logic [1:0]  branch_i;
   logic [31:0] addr_jalr_i, addr_jal_i;
   logic        ready_i;
   logic        valid_o;
   logic [31:0] rdata_o, addr_o;
   logic        err_o;
   logic        instr_req_o, instr_gnt_i;
   logic [31:0] instr_addr_o, instr_rdata_i;
   logic        instr_err_i, instr_rvalid_i;
   logic        busy_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   mm_prefetch_queue #(.NumReqs(2), .FifoDepth(3), .TrapVec(32'h80)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_i          (req_i),
      .branch_i       (branch_i),
      .addr_jalr_i    (addr_jalr_i),
      .addr_jal_i     (addr_jal_i),
      .ready_i        (ready_i),
      .valid_o        (valid_o),
      .rdata_o        (rdata_o),
      .addr_o         (addr_o),
      .err_o          (err_o),
      .instr_req_o    (instr_req_o),
      .instr_gnt_i    (instr_gnt_i),
      .instr_addr_o   (instr_addr_o),
      .instr_rdata_i  (instr_rdata_i),
      .instr_err_i    (instr_err_i),
      .instr_rvalid_i (instr_rvalid_i),
      .busy_o         (busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic req, input logic [1:0] br, input logic gnt,
                        input logic rv, input logic [31:0] rd, input logic er,
                        input logic rdy);
      req_i          = req;
      branch_i       = br;
      instr_gnt_i    = gnt;
      instr_rvalid_i = rv;
      instr_rdata_i  = rd;
      instr_err_i    = er;
      ready_i        = rdy;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_ni      = 1'b0;
      addr_jalr_i = '0;
      addr_jal_i  = '0;
      drive(0, 2'b00, 0, 0, 0, 0, 0);
      #12;
      chk("rst_valid", valid_o, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_addr", addr_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_req", instr_req_o, 0);
      chk("rst_busy", busy_o, 0);
      rst_ni = 1'b1;
      tick();

      // Trap-vector start, streaming with ready_i=1
      drive(1, 2'b11, 1, 0, 0, 0, 1); #1;
      chk("t1_req_a", instr_req_o, 1);
      chk("t1_baddr_a", instr_addr_o, 32'h80);
      tick();
      drive(1, 2'b00, 1, 1, 32'hA000_0080, 0, 1); #1;
      chk("t1_baddr_b", instr_addr_o, 32'h84);
      chk("t1_busy_b", busy_o, 1);
      tick();
      chk("t1_valid_c", valid_o, 1);
      chk("t1_addr_c", addr_o, 32'h80);
      chk("t1_rdata_c", rdata_o, 32'hA000_0080);
      drive(1, 2'b00, 1, 1, 32'hA000_0084, 0, 1); #1;
      chk("t1_baddr_c", instr_addr_o, 32'h88);
      tick();
      chk("t1_addr_d", addr_o, 32'h84);
      chk("t1_rdata_d", rdata_o, 32'hA000_0084);
      drive(0, 2'b00, 0, 1, 32'hA000_0088, 0, 1); #1;
      chk("t1_req_d", instr_req_o, 0);
      chk("t1_busy_d", busy_o, 1);
      tick();
      chk("t1_addr_e", addr_o, 32'h88);
      drive(0, 2'b00, 0, 0, 0, 0, 1); #1;
      chk("t1_busy_e", busy_o, 0);
      tick();
      chk("t1_valid_f", valid_o, 0);

      // Fill with ready_i=0: exactly three words, then requests stop
      drive(1, 2'b11, 1, 0, 0, 0, 0); #1;
      chk("t2_baddr_1", instr_addr_o, 32'h80);
      tick();
      drive(1, 2'b00, 1, 1, 32'hB000_0080, 0, 0); #1;
      chk("t2_baddr_2", instr_addr_o, 32'h84);
      tick();
      drive(1, 2'b00, 1, 1, 32'hB000_0084, 0, 0); #1;
      chk("t2_baddr_3", instr_addr_o, 32'h88);
      tick();
      drive(1, 2'b00, 1, 1, 32'hB000_0088, 0, 0); #1;
      chk("t2_req_4", instr_req_o, 0);
      tick();
      chk("t2_valid_5", valid_o, 1);
      chk("t2_addr_5", addr_o, 32'h80);
      drive(1, 2'b00, 1, 0, 0, 0, 0); #1;
      chk("t2_req_5", instr_req_o, 0);
      tick();
      chk("t2_addr_6", addr_o, 32'h80);
      drive(1, 2'b00, 1, 0, 0, 0, 1); #1;
      chk("t2_req_6", instr_req_o, 0);
      tick();
      chk("t2_addr_7", addr_o, 32'h84);
      drive(1, 2'b00, 1, 0, 0, 0, 0); #1;
      chk("t2_req_7", instr_req_o, 1);
      chk("t2_baddr_7", instr_addr_o, 32'h8C);
      tick();
      drive(0, 2'b00, 0, 1, 32'hB000_008C, 0, 0); #1;
      chk("t2_req_8", instr_req_o, 0);
      tick();
      drive(0, 2'b00, 0, 0, 0, 0, 1); #1;
      chk("t2_drain_84", addr_o, 32'h84);
      tick();
      chk("t2_drain_88", addr_o, 32'h88);
      tick();
      chk("t2_drain_8c", addr_o, 32'h8C);
      chk("t2_drain_rd", rdata_o, 32'hB000_008C);
      tick();
      chk("t2_empty", valid_o, 0);

      // Held request with a JAL redirect while ungranted
      addr_jal_i = 32'h1000;
      drive(1, 2'b00, 0, 0, 0, 0, 0); #1;
      chk("t3_req_1", instr_req_o, 1);
      chk("t3_baddr_1", instr_addr_o, 32'h90);
      tick();
      drive(1, 2'b10, 0, 0, 0, 0, 0); #1;
      chk("t3_baddr_2", instr_addr_o, 32'h90);
      tick();
      drive(1, 2'b00, 0, 0, 0, 0, 0); #1;
      chk("t3_baddr_3", instr_addr_o, 32'h90);
      chk("t3_req_3", instr_req_o, 1);
      tick();
      drive(1, 2'b00, 1, 0, 0, 0, 0); #1;
      chk("t3_baddr_4", instr_addr_o, 32'h90);
      tick();
      drive(1, 2'b00, 1, 1, 32'hDEAD_0090, 0, 1); #1;
      chk("t3_req_5", instr_req_o, 1);
      chk("t3_baddr_5", instr_addr_o, 32'h1000);
      tick();
      chk("t3_drop", valid_o, 0);
      drive(0, 2'b00, 0, 1, 32'hC000_1000, 0, 0); #1;
      tick();
      chk("t3_valid_7", valid_o, 1);
      chk("t3_addr_7", addr_o, 32'h1000);
      chk("t3_rdata_7", rdata_o, 32'hC000_1000);

      // Two outstanding, JALR redirect with simultaneous rvalid
      addr_jalr_i = 32'h2002;
      drive(1, 2'b11, 1, 0, 0, 0, 1); #1;
      chk("t4_baddr_1", instr_addr_o, 32'h80);
      tick();
      drive(1, 2'b00, 1, 1, 32'hE000_0080, 0, 0); #1;
      chk("t4_baddr_2", instr_addr_o, 32'h84);
      tick();
      drive(1, 2'b00, 1, 0, 0, 0, 0); #1;
      chk("t4_baddr_3", instr_addr_o, 32'h88);
      tick();
      chk("t4_valid_4", valid_o, 1);
      chk("t4_addr_4", addr_o, 32'h80);
      drive(1, 2'b01, 1, 1, 32'hE000_0084, 0, 0); #1;
      chk("t4_req_4", instr_req_o, 0);
      tick();
      chk("t4_cleared", valid_o, 0);
      drive(1, 2'b00, 1, 1, 32'hE000_0088, 0, 0); #1;
      chk("t4_req_5", instr_req_o, 1);
      chk("t4_baddr_5", instr_addr_o, 32'h2000);
      tick();
      chk("t4_drop88", valid_o, 0);
      drive(0, 2'b00, 0, 1, 32'hE000_2000, 0, 0); #1;
      tick();
      chk("t4_valid_7", valid_o, 1);
      chk("t4_addr_7", addr_o, 32'h2000);
      chk("t4_rdata_7", rdata_o, 32'hE000_2000);

      // Bus error on the word at 0x90
      addr_jal_i = 32'h90;
      drive(1, 2'b10, 1, 0, 0, 0, 1); #1;
      chk("t5_baddr_1", instr_addr_o, 32'h90);
      tick();
      drive(1, 2'b00, 1, 1, 32'hF000_0090, 1, 1); #1;
      chk("t5_baddr_2", instr_addr_o, 32'h94);
      tick();
      chk("t5_addr_3", addr_o, 32'h90);
      chk("t5_err_3", err_o, 1);
      drive(0, 2'b00, 0, 1, 32'hF000_0094, 0, 1); #1;
      tick();
      chk("t5_addr_4", addr_o, 32'h94);
      chk("t5_err_4", err_o, 0);
      drive(0, 2'b00, 0, 0, 0, 0, 1); #1;
      tick();
      chk("t5_empty", valid_o, 0);

      // Reset with requests in flight and words buffered
      drive(1, 2'b11, 1, 0, 0, 0, 0); #1;
      tick();
      drive(1, 2'b00, 1, 1, 32'hA5A5_0080, 0, 0); #1;
      tick();
      drive(1, 2'b00, 1, 0, 0, 0, 0); #1;
      chk("t6_baddr_3", instr_addr_o, 32'h88);
      tick();
      chk("t6_valid_pre", valid_o, 1);
      chk("t6_busy_pre", busy_o, 1);
      drive(1, 2'b00, 0, 0, 0, 0, 0);
      rst_ni = 1'b0; #1;
      chk("t6_valid", valid_o, 0);
      chk("t6_rdata", rdata_o, 0);
      chk("t6_addr", addr_o, 0);
      chk("t6_err", err_o, 0);
      chk("t6_req", instr_req_o, 0);
      chk("t6_baddr", instr_addr_o, 0);
      chk("t6_busy", busy_o, 0);
      #1 rst_ni = 1'b1;
      tick();
      drive(1, 2'b00, 0, 1, 32'hBAD0_0084, 0, 0); #1;
      chk("t6_req_post", instr_req_o, 0);
      tick();
      chk("t6_late_1", valid_o, 0);
      drive(1, 2'b00, 0, 1, 32'hBAD0_0088, 0, 0); #1;
      tick();
      chk("t6_late_2", valid_o, 0);
      chk("t6_busy_post", busy_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
